// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches operands, streams one bit pair per clock LSB first
// through a half-adder-pair full-adder cell, and presents the sum with a one-cycle done pulse.

module serial_adder_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   reg_a, reg_b, sreg;
  logic [WIDTH-1:0]   sreg_nxt;
  logic               cff;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               s1, c1, s_bit, c2, c_bit;

  // Full adder = two half adders plus an OR on the carries.
  serial_adder_ha u_ha0 (.a(reg_a[0]), .b(reg_b[0]), .s(s1),    .c(c1));
  serial_adder_ha u_ha1 (.a(s1),       .b(cff),      .s(s_bit), .c(c2));
  assign c_bit    = c1 | c2;
  assign sreg_nxt = {s_bit, sreg[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
      sreg  <= '0;
      cff   <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          reg_a <= ip1;
          reg_b <= ip2;
          cff   <= cin;
          cnt   <= '0;
        end
        SHIFT: begin
          reg_a <= reg_a >> 1;
          reg_b <= reg_b >> 1;
          sreg  <= sreg_nxt;
          cff   <= c_bit;
          cnt   <= cnt + 1'b1;
          // Outputs update atomically on the final bit edge only.
          if (last_bit) begin
            sum   <= sreg_nxt;
            carry <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expected {carry,sum} and done
// cycle; a negedge monitor pops and compares on every done pulse.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] ip1 = '0, ip2 = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  typedef struct {
    logic [W:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cyc = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ip1(ip1), .ip2(ip2), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {23'd0, carry, sum}, {23'd0, e.res});
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Drive one request from an IDLE cycle; returns at the first SHIFT-cycle negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W:0] exp);
    @(negedge clk);
    ip1 = a; ip2 = b; cin = c; start = 1'b1;
    acc_cyc = cyc + 1;
    sb.push_back('{res: exp, cyc: cyc + W + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int t = 0; t < 20; t++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    // Reset then idle
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs", {28'd0, busy, done, carry, |sum}, 32'd0);
    end

    // Basic add with busy-length check
    issue(8'h5A, 8'h33, 1'b0, 9'h08D);
    for (int i = 0; i < 9; i++) begin
      check("busy_high", busy, 1);
      @(negedge clk);
    end
    check("busy_low", busy, 0);

    // Carry chains
    issue(8'hFF, 8'h01, 1'b0, 9'h100); wait_done();
    issue(8'hFF, 8'hFF, 1'b1, 9'h1FF); wait_done();
    issue(8'hFF, 8'h00, 1'b1, 9'h100); wait_done();

    // Start while busy is ignored
    issue(8'h10, 8'h20, 1'b0, 9'h030);
    @(negedge clk); @(negedge clk);
    ip1 = 8'hAA; ip2 = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_outs", {23'd0, carry, sum}, 32'h030);
      check("hold_busy", {30'd0, busy, done}, 0);
      @(negedge clk);
    end

    // Asynchronous reset mid-operation
    issue(8'hC3, 8'h3C, 1'b0, 9'h0FF);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_outs", {23'd0, busy, done, carry, sum}, 0);
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("rst_hold", {23'd0, busy, done, carry, sum}, 0);
    rst = 1'b0;
    issue(8'h01, 8'h02, 1'b0, 9'h003); wait_done();

    // Back-to-back random
    begin
      int prev = 0;
      for (int i = 0; i < 1000; i++) begin
        logic [W-1:0] a, b;
        logic         c;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        issue(a, b, c, {1'b0, a} + {1'b0, b} + {8'd0, c});
        if (i > 0) check("spacing", acc_cyc - prev, W + 2);
        prev = acc_cyc;
        wait_done();
      end
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that sits upstream of the 1-bit adder cell.
- Latches two parallel operands and a carry-in, then streams one bit pair per clock, LSB first, through a full-adder cell built from two half adders plus an OR.
- Recirculates the carry in a flip-flop and reassembles the sum in a shift register.
- Presents the parallel result with a one-cycle done pulse. Trades latency for area against a ripple-carry adder.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal: 2..32).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous active-high reset
- start  input   1      request; sampled only in IDLE
- ip1    input   WIDTH  operand A; sampled on the accepted start edge
- ip2    input   WIDTH  operand B; sampled on the accepted start edge
- cin    input   1      carry-in; sampled on the accepted start edge
- busy   output  1      high in SHIFT and DONE
- done   output  1      one-cycle pulse when sum/carry are updated
- sum    output  WIDTH  registered result, held until the next done
- carry  output  1      registered carry-out, held with sum

Behaviour:
- Reset: one clock and one asynchronous active-high reset. rst asserted at any time, including mid-operation, immediately forces:
  - state=IDLE;
  - busy=0, done=0, sum=0, carry=0;
  - internal operand shift registers, sum shift register, carry FF and bit counter all to 0.
- The in-flight operation is discarded with no done pulse. Operation resumes on the first clk edge after rst deasserts.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: load regA=ip1, regB=ip2, cff=cin, cnt=0; go to SHIFT.
  - With start=0: stay in IDLE.
- SHIFT, each edge:
  - Form s = regA[0]^regB[0]^cff and c = (regA[0]&regB[0]) | (cff&(regA[0]^regB[0])).
  - Shift regA and regB right by one (MSB filled with 0).
  - Shift s into the MSB of the sum shift register (right shift).
  - cff<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge, go to DONE and load the output registers: sum<=next sum-shift-register value, carry<=c.
- DONE: done=1 for exactly this one cycle, then unconditionally back to IDLE.
- busy = (state!=IDLE), decoded from the state register; done = (state==DONE), registered/state-decoded with no combinational path from inputs.
- Latency: start accepted at edge E0 → SHIFT during cycles after E0..E(WIDTH) → done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after acceptance. sum and carry change at edge E(WIDTH) only.
- Throughput: a new start can be accepted at the earliest on the edge leaving DONE+1, i.e. one request per WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored, with no queueing. Operand changes while busy have no effect.
- Arithmetic is modulo 2^WIDTH on sum; carry = bit WIDTH of ip1+ip2+cin.
- Outputs hold their last value indefinitely in IDLE; the next result overwrites them atomically.

Test Plan (WIDTH=8):
- Reset then idle: rst pulse, start=0 for 20 cycles → busy=0, done=0, sum=8'h00, carry=0 throughout.
- Basic add: ip1=8'h5A, ip2=8'h33, cin=0, start for 1 cycle → done high exactly 9 cycles after the accepting edge, sum=8'h8D, carry=0; busy high 9 cycles.
- Carry chain: 8'hFF+8'h01, cin=0 → sum=8'h00, carry=1. Also 8'hFF+8'hFF, cin=1 → sum=8'hFF, carry=1. Also 8'hFF+8'h00, cin=1 → sum=8'h00, carry=1.
- Busy ignore: start 8'h10+8'h20, then reassert start with 8'hAA+8'h55 during SHIFT cycle 3 and during DONE → single done pulse, sum=8'h30, carry=0. Outputs unchanged for the following 10 cycles unless start is given in IDLE.
- Reset mid-operation: start 8'hC3+8'h3C, assert rst asynchronously (between edges) in SHIFT cycle 4 → busy/done/sum/carry go to 0 immediately, with no done pulse. After release, 8'h01+8'h02 → sum=8'h03 after 9 cycles.
- Back-to-back + random: issue start on the first IDLE cycle after each done, for 1000 random ip1/ip2/cin → every result equals {carry,sum}==ip1+ip2+cin, and starts are spaced exactly 10 cycles apart.
